// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle CPU control path (states, opcodes, ALUOp, mux selects).
// Latency: n/a (constants only).
// Backpressure: n/a.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_MEM, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_EX_R,
    S_WB_R, S_EX_I, S_WB_I, S_BR, S_J, S_JAL, S_JR
  } state_t;

  // Where the FSM goes after ID.
  typedef enum logic [2:0] {
    CLS_NOP, CLS_MEM, CLS_R, CLS_JR, CLS_I, CLS_BR, CLS_J, CLS_JAL
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // ALUOp[2:0] base operation; ALUOp[3] is the unsigned flag.
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS    = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

endpackage

// File: rtl/multicycle_controller_instr_class_decode.sv
// Combinational opcode/funct classifier: post-ID class plus shift/unsigned/jalr flags. BNE_EN adds bne.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module instr_class_decode
  import multicycle_controller_pkg::*;
(
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic [2:0] instr_class,
  output logic       is_shift,
  output logic       is_unsigned,
  output logic       is_jalr
);

  // Classify the latched instruction; unknown opcodes fall through as nop.
  always_comb begin
    instr_class = CLS_NOP;
    is_shift    = (Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA);
    is_jalr     = (Funct == FN_JALR);
    is_unsigned = OpCode[0];
    case (OpCode)
      OP_LW, OP_SW: instr_class = CLS_MEM;
      OP_RTYPE:     instr_class = ((Funct == FN_JR) || (Funct == FN_JALR)) ? CLS_JR : CLS_R;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI:
                    instr_class = CLS_I;
      OP_BEQ:       instr_class = CLS_BR;
`ifdef BNE_EN
      OP_BNE:       instr_class = CLS_BR;
`endif
      OP_J:         instr_class = CLS_J;
      OP_JAL:       instr_class = CLS_JAL;
      default:      instr_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main multi-cycle CPU control FSM driving all datapath enables/selects and ALUOp. BNE_EN enables bne.
// Latency: lw 5, R/I-ALU/sw 4, branch/jump 3, illegal 2 cycles; outputs combinational from state.
// Backpressure: none; the FSM advances every cycle, reset aborts the current instruction.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource
);

  state_t     state, next_state;
  logic [2:0] cls_raw;
  logic       is_shift, is_unsigned, is_jalr;
  logic [2:0] imm_alu;

  instr_class_decode u_decode (
    .OpCode      (OpCode),
    .Funct       (Funct),
    .instr_class (cls_raw),
    .is_shift    (is_shift),
    .is_unsigned (is_unsigned),
    .is_jalr     (is_jalr)
  );

  // Map the class reported by the decoder onto the first post-ID state.
  function automatic state_t class_to_state(input logic [2:0] c);
    case (instr_class_t'(c))
      CLS_MEM: return S_EX_MEM;
      CLS_R:   return S_EX_R;
      CLS_JR:  return S_JR;
      CLS_I:   return S_EX_I;
      CLS_BR:  return S_BR;
      CLS_J:   return S_J;
      CLS_JAL: return S_JAL;
      default: return S_IF;
    endcase
  endfunction

  // Base ALU operation for the immediate-ALU group.
  always_comb begin
    case (OpCode)
      OP_ANDI:           imm_alu = ALU_AND;
      OP_SLTI, OP_SLTIU: imm_alu = ALU_SLT;
      default:           imm_alu = ALU_ADD;
    endcase
  end

  // State register; reset always restarts at fetch.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IF;
    else       state <= next_state;
  end

  // Next-state and Moore outputs; reset forces every output low.
  always_comb begin
    next_state  = S_IF;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = MTR_ALUOUT;
    RegDst      = DST_RT;
    RegWrite    = 1'b0;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RT;
    ALUOp       = {1'b0, ALU_ADD};
    PCSource    = PCSRC_ALU;
    if (!reset) begin
      case (state)
        S_IF: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = SRCB_FOUR;
          next_state = S_ID;
        end
        S_ID: begin
          // Precompute the branch target into ALUOut.
          ALUSrcB    = SRCB_IMM_SH2;
          next_state = class_to_state(cls_raw);
        end
        S_EX_MEM: begin
          ALUSrcA    = SRCA_RS;
          ALUSrcB    = SRCB_IMM;
          ExtOp      = 1'b1;
          next_state = (OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          MemRead    = 1'b1;
          IorD       = 1'b1;
          next_state = S_WB_MEM;
        end
        S_WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = MTR_MDR;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EX_R: begin
          ALUOp      = {1'b0, ALU_FUNCT};
          ALUSrcA    = is_shift ? SRCA_SHAMT : SRCA_RS;
          next_state = S_WB_R;
        end
        S_WB_R: begin
          RegWrite = 1'b1;
          RegDst   = DST_RD;
        end
        S_EX_I: begin
          ALUSrcA    = SRCA_RS;
          ALUSrcB    = SRCB_IMM;
          ExtOp      = (OpCode != OP_ANDI);
          LuiOp      = (OpCode == OP_LUI);
          ALUOp      = {is_unsigned, imm_alu};
          next_state = S_WB_I;
        end
        S_WB_I: RegWrite = 1'b1;
        S_BR: begin
          ALUSrcA     = SRCA_RS;
          ALUOp       = {1'b0, ALU_SUB};
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
`ifdef BNE_EN
          BranchNe    = OpCode[0];
`endif
        end
        S_J: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        S_JAL: begin
          // PC already holds PC+4, which is the link value.
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
          RegWrite = 1'b1;
          RegDst   = DST_RA;
          MemtoReg = MTR_PC;
        end
        S_JR: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_RS;
          if (is_jalr) begin
            RegWrite = 1'b1;
            RegDst   = DST_RD;
            MemtoReg = MTR_PC;
          end
        end
        default: next_state = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against a per-instruction control-word model.
// Latency: n/a.
// Backpressure: n/a.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw, pcwc, bne, iord, mrd, mwr, irw;
    logic [1:0] mtr, dst;
    logic       rw, ext, lui;
    logic [1:0] sa, sb;
    logic [3:0] aluop;
    logic [1:0] pcs;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] MemtoReg, RegDst;
  logic       RegWrite, ExtOp, LuiOp;
  logic [1:0] ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;
  ctrl_t      got;

  int vectors = 0;
  int miscompares = 0;

`ifdef BNE_EN
  bit bne_on = 1'b1;
`else
  bit bne_on = 1'b0;
`endif

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ExtOp(ExtOp), .LuiOp(LuiOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource)
  );

  assign got = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ExtOp, LuiOp, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  task automatic check_vec(input string tag, input ctrl_t obs, input ctrl_t exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected control word for every cycle of one instruction, by mnemonic.
  ctrl_t exp_q[$];

  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    exp_q.delete();
    c = '0; c.mrd = 1; c.irw = 1; c.pcw = 1; c.sb = 2'b01;           // fetch, PC+4
    exp_q.push_back(c);
    c = '0; c.sb = 2'b11;                                            // decode, branch target
    exp_q.push_back(c);
    if (op == 6'h23 || op == 6'h2B) begin
      c = '0; c.sa = 2'b01; c.sb = 2'b10; c.ext = 1;                 // address calc
      exp_q.push_back(c);
      if (op == 6'h23) begin
        c = '0; c.mrd = 1; c.iord = 1; exp_q.push_back(c);
        c = '0; c.rw = 1; c.mtr = 2'b01; exp_q.push_back(c);
      end else begin
        c = '0; c.mwr = 1; c.iord = 1; exp_q.push_back(c);
      end
    end else if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) begin
      c = '0; c.pcw = 1; c.pcs = 2'b11;
      if (fn == 6'h09) begin c.rw = 1; c.dst = 2'b01; c.mtr = 2'b10; end
      exp_q.push_back(c);
    end else if (op == 6'h00) begin
      c = '0; c.aluop = 4'b0010;
      c.sa = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'b10 : 2'b01;
      exp_q.push_back(c);
      c = '0; c.rw = 1; c.dst = 2'b01; exp_q.push_back(c);
    end else if (op == 6'h08 || op == 6'h09 || op == 6'h0A || op == 6'h0B ||
                 op == 6'h0C || op == 6'h0F) begin
      c = '0; c.sa = 2'b01; c.sb = 2'b10;
      c.ext = (op != 6'h0C);
      c.lui = (op == 6'h0F);
      if (op == 6'h0C)                    c.aluop[2:0] = 3'b100;
      else if (op == 6'h0A || op == 6'h0B) c.aluop[2:0] = 3'b101;
      else                                c.aluop[2:0] = 3'b000;
      c.aluop[3] = op[0];
      exp_q.push_back(c);
      c = '0; c.rw = 1; exp_q.push_back(c);
    end else if (op == 6'h04 || (op == 6'h05 && bne_on)) begin
      c = '0; c.sa = 2'b01; c.aluop = 4'b0001; c.pcwc = 1; c.pcs = 2'b01;
      c.bne = (op == 6'h05);
      exp_q.push_back(c);
    end else if (op == 6'h02) begin
      c = '0; c.pcw = 1; c.pcs = 2'b10; exp_q.push_back(c);
    end else if (op == 6'h03) begin
      c = '0; c.pcw = 1; c.pcs = 2'b10; c.rw = 1; c.dst = 2'b10; c.mtr = 2'b10;
      exp_q.push_back(c);
    end
    // anything else: fetch + decode only
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit allow_abort);
    int abort_at;
    model_instr(op, fn);
    abort_at = -1;
    if (allow_abort && $urandom_range(0, 9) == 0)
      abort_at = $urandom_range(1, exp_q.size() - 1);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == 0) begin
        OpCode = 6'($urandom);
        Funct  = 6'($urandom);
      end else begin
        OpCode = op;
        Funct  = fn;
      end
      if (k == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        check_vec("reset_abort", got, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      check_vec($sformatf("op%02h_fn%02h_cyc%0d", op, fn, k), got, exp_q[k]);
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] op_pool [13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                               6'h0A, 6'h0B, 6'h0C, 6'h0F, 6'h23, 6'h2B};
  logic [5:0] fn_pool [7]  = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h2A};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] op, fn;
    reset  = 1'b1;
    OpCode = 6'h00;
    Funct  = 6'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_vec("reset_idle", got, '0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(6'h23, 6'h00, 1'b0);   // lw
    run_instr(6'h00, 6'h00, 1'b0);   // sll
    run_instr(6'h00, 6'h2A, 1'b0);   // slt
    run_instr(6'h0B, 6'h15, 1'b0);   // sltiu
    run_instr(6'h0C, 6'h3F, 1'b0);   // andi
    run_instr(6'h03, 6'h00, 1'b0);   // jal
    run_instr(6'h3F, 6'h00, 1'b0);   // illegal
    run_instr(6'h05, 6'h00, 1'b0);   // bne / illegal
    run_instr(6'h04, 6'h00, 1'b0);   // beq
    run_instr(6'h00, 6'h09, 1'b0);   // jalr
    run_instr(6'h2B, 6'h00, 1'b0);   // sw
    run_instr(6'h0F, 6'h00, 1'b0);   // lui

    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 12)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 6)];
      run_instr(op, fn, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
